// File: rtl/data_mem_ctrl.sv
// Data-memory controller: turns memory-stage loads/stores into single-beat
// bus transactions, aligns store lanes, extends load data and guards each
// bus wait with a timeout so a dead slave can never hang the pipeline.
module data_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_Read_M,
  input  logic        Mem_Write_M,
  input  logic [2:0]  Funct3_M,
  input  logic [31:0] Alu_Result_M,
  input  logic [31:0] WriteData_Mem,
  output logic        Bus_Req,
  output logic        Bus_We,
  output logic [31:0] Bus_Addr,
  output logic [31:0] Bus_WData,
  output logic [3:0]  Bus_BE,
  input  logic        Bus_Ack,
  input  logic [31:0] Bus_RData,
  output logic [31:0] ReadData_Memory,
  output logic        Mem_Stall,
  output logic        Misaligned,
  output logic        Bus_Timeout
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  // Count value at which the current no-ack WAIT cycle is the last one allowed.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  // Size code is Funct3[1:0]: 00 byte, 01 half, anything else a full word.
  function automatic logic calc_misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] calc_store_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] calc_store_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Lane select by the saved low address bits, then sign/zero extend.
  function automatic logic [31:0] calc_load_data(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'b00:   b = rd[7:0];
      2'b01:   b = rd[15:8];
      2'b10:   b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return rd;
    endcase
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_wait_cnt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic        r_is_load;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_be;
  logic [31:0] r_read_data;
  logic        r_bus_timeout;

  logic        w_access;
  logic        w_is_store;
  logic        w_addr_bad;
  logic        w_stall;
  logic        w_misaligned;
  logic        w_start;
  logic        w_ack_done;
  logic        w_timeout_hit;

  assign w_access   = Mem_Read_M | Mem_Write_M;
  assign w_is_store = Mem_Write_M;
  assign w_addr_bad = calc_misaligned(Funct3_M[1:0], Alu_Result_M[1:0]);

  // Next-state decode plus the combinational stall/misaligned flags.
  always_comb begin
    w_state_nxt   = r_state;
    w_stall       = 1'b0;
    w_misaligned  = 1'b0;
    w_start       = 1'b0;
    w_ack_done    = 1'b0;
    w_timeout_hit = 1'b0;
    if (Reset) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_access && w_addr_bad) begin
            w_misaligned = 1'b1;
          end else if (w_access) begin
            w_stall     = 1'b1;
            w_start     = 1'b1;
            w_state_nxt = WAIT;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        WAIT: begin
          w_stall = 1'b1;
          if (Bus_Ack) begin
            w_ack_done  = 1'b1;
            w_state_nxt = DONE;
          end else if (r_wait_cnt == TO_LAST) begin
            w_timeout_hit = 1'b1;
            w_state_nxt   = DONE;
          end else begin
            w_state_nxt = WAIT;
          end
        end
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bus outputs, wait counter, access context and load result registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wait_cnt    <= 8'd0;
      r_funct3      <= 3'd0;
      r_addr_lo     <= 2'd0;
      r_is_load     <= 1'b0;
      r_bus_req     <= 1'b0;
      r_bus_we      <= 1'b0;
      r_bus_addr    <= 32'd0;
      r_bus_wdata   <= 32'd0;
      r_bus_be      <= 4'd0;
      r_read_data   <= 32'd0;
      r_bus_timeout <= 1'b0;
    end else begin
      r_bus_timeout <= w_timeout_hit;
      if (w_start) begin
        r_wait_cnt  <= 8'd0;
        r_funct3    <= Funct3_M;
        r_addr_lo   <= Alu_Result_M[1:0];
        r_is_load   <= ~w_is_store;
        r_bus_req   <= 1'b1;
        r_bus_we    <= w_is_store;
        r_bus_addr  <= {Alu_Result_M[31:2], 2'b00};
        r_bus_wdata <= calc_store_data(Funct3_M[1:0], WriteData_Mem);
        r_bus_be    <= w_is_store ? calc_store_be(Funct3_M[1:0], Alu_Result_M[1:0]) : 4'b1111;
      end else if (w_ack_done) begin
        r_bus_req <= 1'b0;
        r_bus_we  <= 1'b0;
        if (r_is_load) begin
          r_read_data <= calc_load_data(r_funct3, r_addr_lo, Bus_RData);
        end
      end else if (w_timeout_hit) begin
        r_bus_req <= 1'b0;
        r_bus_we  <= 1'b0;
        if (r_is_load) begin
          r_read_data <= 32'd0;
        end
      end else if (r_state == WAIT) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
    end
  end

  assign Bus_Req         = r_bus_req;
  assign Bus_We          = r_bus_we;
  assign Bus_Addr        = r_bus_addr;
  assign Bus_WData       = r_bus_wdata;
  assign Bus_BE          = r_bus_be;
  assign ReadData_Memory = r_read_data;
  assign Bus_Timeout     = r_bus_timeout;
  assign Mem_Stall       = w_stall;
  assign Misaligned      = w_misaligned;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed corner cases followed by
// randomized transactions compared against a transaction-level model.
module tb_data_mem_ctrl;

  localparam int TO = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Mem_Read_M;
  logic        Mem_Write_M;
  logic [2:0]  Funct3_M;
  logic [31:0] Alu_Result_M;
  logic [31:0] WriteData_Mem;
  logic        Bus_Req;
  logic        Bus_We;
  logic [31:0] Bus_Addr;
  logic [31:0] Bus_WData;
  logic [3:0]  Bus_BE;
  logic        Bus_Ack;
  logic [31:0] Bus_RData;
  logic [31:0] ReadData_Memory;
  logic        Mem_Stall;
  logic        Misaligned;
  logic        Bus_Timeout;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_rd;    // model of ReadData_Memory

  data_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Reset(Reset), .Mem_Read_M(Mem_Read_M), .Mem_Write_M(Mem_Write_M),
    .Funct3_M(Funct3_M), .Alu_Result_M(Alu_Result_M), .WriteData_Mem(WriteData_Mem),
    .Bus_Req(Bus_Req), .Bus_We(Bus_We), .Bus_Addr(Bus_Addr), .Bus_WData(Bus_WData),
    .Bus_BE(Bus_BE), .Bus_Ack(Bus_Ack), .Bus_RData(Bus_RData),
    .ReadData_Memory(ReadData_Memory), .Mem_Stall(Mem_Stall), .Misaligned(Misaligned),
    .Bus_Timeout(Bus_Timeout)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int access_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    else if (f3[1:0] == 2'b01) return 2;
    else return 4;
  endfunction

  // Take access_bytes bytes starting at byte offset addr%4 and extend.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int sz;
    int off;
    logic [31:0] v;
    logic [31:0] mask;
    sz  = access_bytes(f3);
    off = int'(addr % 4);
    if (sz == 4) return rdata;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v    = (rdata >> (8 * off)) & mask;
    if (!f3[2] && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic idle_inputs();
    Mem_Read_M    = 1'b0;
    Mem_Write_M   = 1'b0;
    Funct3_M      = 3'b000;
    Alu_Result_M  = 32'd0;
    WriteData_Mem = 32'd0;
    Bus_Ack       = 1'b0;
    Bus_RData     = 32'd0;
  endtask

  // One instruction in the memory stage; dly = WAIT cycle carrying the ack.
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdata, input int dly);
    int sz;
    int off;
    int nwait;
    logic mis;
    logic to;
    logic [3:0] ebe;
    logic [31:0] ewd;
    sz  = access_bytes(f3);
    off = int'(addr % 4);
    mis = (addr % sz) != 0;
    ebe = wr ? 4'(((1 << sz) - 1) << off) : 4'b1111;
    for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % sz) +: 8];
    to    = dly > TO;
    nwait = to ? TO : dly;

    @(posedge Clk); #1;
    Mem_Read_M = rd; Mem_Write_M = wr; Funct3_M = f3;
    Alu_Result_M = addr; WriteData_Mem = wd; Bus_Ack = 1'b0;
    @(negedge Clk);
    check_val("misaligned", 32'(Misaligned), 32'(mis));
    check_val("stall_idle", 32'(Mem_Stall), 32'(!mis));
    check_val("req_idle", 32'(Bus_Req), 32'd0);
    check_val("timeout_idle", 32'(Bus_Timeout), 32'd0);
    if (mis) begin
      @(posedge Clk); #1;
      idle_inputs();
      @(negedge Clk);
      check_val("mis_no_req", 32'(Bus_Req), 32'd0);
      check_val("mis_rdata", ReadData_Memory, m_rd);
      return;
    end

    for (int w = 1; w <= nwait; w++) begin
      @(posedge Clk); #1;
      Bus_Ack   = (w == dly);
      Bus_RData = (w == dly) ? rdata : $urandom;
      @(negedge Clk);
      check_val("stall_wait", 32'(Mem_Stall), 32'd1);
      check_val("req_wait", 32'(Bus_Req), 32'd1);
      check_val("we_wait", 32'(Bus_We), 32'(wr));
      check_val("addr_wait", Bus_Addr, {addr[31:2], 2'b00});
      check_val("be_wait", 32'(Bus_BE), 32'(ebe));
      if (wr) check_val("wdata_wait", Bus_WData, ewd);
    end

    @(posedge Clk); #1;
    Bus_Ack = 1'b0;
    if (!wr) m_rd = to ? 32'd0 : model_load(f3, addr, rdata);
    @(negedge Clk);
    check_val("stall_done", 32'(Mem_Stall), 32'd0);
    check_val("req_done", 32'(Bus_Req), 32'd0);
    check_val("we_done", 32'(Bus_We), 32'd0);
    check_val("timeout_done", 32'(Bus_Timeout), 32'(to));
    check_val("rdata_done", ReadData_Memory, m_rd);
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_req"}, 32'(Bus_Req), 32'd0);
    check_val({tag, "_we"}, 32'(Bus_We), 32'd0);
    check_val({tag, "_addr"}, Bus_Addr, 32'd0);
    check_val({tag, "_wdata"}, Bus_WData, 32'd0);
    check_val({tag, "_be"}, 32'(Bus_BE), 32'd0);
    check_val({tag, "_rdata"}, ReadData_Memory, 32'd0);
    check_val({tag, "_timeout"}, 32'(Bus_Timeout), 32'd0);
  endtask

  // Start a load, let it sit in WAIT, then pulse Reset.
  task automatic reset_mid_wait();
    @(posedge Clk); #1;
    Mem_Read_M = 1'b1; Mem_Write_M = 1'b0; Funct3_M = 3'b010;
    Alu_Result_M = 32'h0000_0400; Bus_Ack = 1'b0;
    @(posedge Clk); #1;
    @(negedge Clk);
    check_val("rst_pre_req", 32'(Bus_Req), 32'd1);
    @(posedge Clk); #1;
    Reset = 1'b1;
    Alu_Result_M = 32'h0000_0401;
    @(negedge Clk);
    check_val("rst_stall", 32'(Mem_Stall), 32'd0);
    check_val("rst_mis", 32'(Misaligned), 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    idle_inputs();
    m_rd = 32'd0;
    @(negedge Clk);
    check_reset_values("rst_mid");
    check_val("rst_mid_stall", 32'(Mem_Stall), 32'd0);
  endtask

  initial begin
    int op;
    logic [31:0] a;
    idle_inputs();
    Reset = 1'b1;
    m_rd  = 32'd0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_reset_values("reset");
    check_val("reset_stall", 32'(Mem_Stall), 32'd0);
    check_val("reset_mis", 32'(Misaligned), 32'd0);
    #1 Reset = 1'b0;

    // LB at 0x103, ack on second WAIT cycle
    run_txn(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_FF00, 2);
    check_val("lb_result", ReadData_Memory, 32'hFFFF_FF80);
    // SH at 0x202
    run_txn(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'd0, 1);
    check_val("sh_rdata_kept", ReadData_Memory, 32'hFFFF_FF80);
    // LW at 0x201 is misaligned
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0201, 32'd0, 32'd0, 1);
    // LHU at 0 with no ack: timeout
    run_txn(1'b1, 1'b0, 3'b101, 32'h0000_0000, 32'd0, 32'd0, 1000);
    check_val("lhu_timeout_rd", ReadData_Memory, 32'd0);
    // Ack on the limit cycle wins over timeout
    run_txn(1'b1, 1'b0, 3'b001, 32'h0000_0012, 32'd0, 32'h9234_5678, TO);
    // Load and store together: store wins
    run_txn(1'b1, 1'b1, 3'b010, 32'h0000_0300, 32'h1234_5678, 32'hDEAD_BEEF, 1);
    // Reset pulsed in WAIT
    reset_mid_wait();
    run_txn(1'b1, 1'b0, 3'b100, 32'h0000_0041, 32'd0, 32'h0000_F700, 1);

    for (int k = 0; k < 200; k++) begin
      op = int'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      run_txn(op != 1, op != 0, 3'($urandom_range(0, 7)), a, $urandom, $urandom,
              int'($urandom_range(1, TO + 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max bus-wait cycles before an access is aborted; range 1-255.
REQ-002 Clk  in  1  single clock; all state updates on rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset; sampled on the rising edge of Clk.
REQ-004 Mem_Read_M  in  1  memory-stage load request.
REQ-005 Mem_Write_M  in  1  memory-stage store request.
REQ-006 Funct3_M  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 Alu_Result_M  in  32  byte address of the access.
REQ-008 WriteData_Mem  in  32  store data, right-aligned.
REQ-009 Bus_Req  out  1  bus request, registered.
REQ-010 Bus_We  out  1  bus write strobe, registered.
REQ-011 Bus_Addr  out  32  word address: Alu_Result_M with [1:0] forced to 00, registered.
REQ-012 Bus_WData  out  32  lane-aligned store data, registered.
REQ-013 Bus_BE  out  4  byte enables, registered.
REQ-014 Bus_Ack  in  1  bus completion; Bus_RData valid in the same cycle.
REQ-015 Bus_RData  in  32  bus read word.
REQ-016 ReadData_Memory  out  32  extended load result, registered, feeds the writeback pipeline register.
REQ-017 Mem_Stall  out  1  combinational stall request to the hazard unit.
REQ-018 Misaligned  out  1  combinational misaligned-access flag.
REQ-019 Bus_Timeout  out  1  one-cycle pulse when an access is aborted.

Function
REQ-020 FSM states SHALL be IDLE, WAIT, DONE.
REQ-021 Access = Mem_Read_M | Mem_Write_M; if both are high, the store SHALL win and the load SHALL be ignored.
REQ-022 Misaligned SHALL be 1 in IDLE when an access is halfword with addr[0]=1, or word with addr[1:0]!=00; it SHALL be 0 otherwise.
REQ-023 A misaligned access SHALL not start a bus cycle, SHALL not stall, and SHALL leave ReadData_Memory unchanged.
REQ-024 IDLE with an aligned access: Mem_Stall=1 in that cycle; at the next edge Bus_Req=1, Bus_We=store, Bus_Addr, Bus_WData and Bus_BE are loaded, and the FSM goes to WAIT.
REQ-025 Byte store: Bus_BE=0001<<addr[1:0], Bus_WData = byte replicated x4.
REQ-026 Halfword store: Bus_BE=0011 or 1100 selected by addr[1], Bus_WData = half replicated x2.
REQ-027 Word store: Bus_BE=1111.
REQ-028 Loads SHALL drive Bus_BE=1111 for all sizes.
REQ-029 Funct3 encodings not listed in REQ-006 SHALL be treated as word accesses.
REQ-030 WAIT: Mem_Stall=1; Bus_Req and the other bus outputs SHALL hold stable until Bus_Ack.
REQ-031 WAIT with Bus_Ack=1: at the edge, Bus_Req=0 and Bus_We=0, and on a load ReadData_Memory loads the lane-selected, extended Bus_RData; the FSM goes to DONE.
REQ-032 Load extension: LB/LH sign-extend; LBU/LHU zero-extend; the byte lane is selected by addr[1:0] and the half lane by addr[1].
REQ-033 DONE: Mem_Stall=0 for exactly one cycle so the pipeline advances; the FSM SHALL go to IDLE unconditionally, so the same instruction is never re-issued.
REQ-034 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without Bus_Ack.
REQ-035 Timeout: if the count reaches TIMEOUT_CYCLES without Bus_Ack, at the next edge Bus_Req=0, Bus_Timeout=1 for one cycle, a load writes ReadData_Memory=0, and the FSM goes to DONE.
REQ-036 If Bus_Ack arrives in the same cycle the limit is reached, the ack SHALL win and no timeout SHALL be signalled.
REQ-037 ReadData_Memory SHALL hold its value between loads; stores SHALL not modify it.

Reset
REQ-038 On a Clk edge with Reset=1: state=IDLE; wait counter=0; Bus_Req, Bus_We, Bus_Timeout=0; Bus_Addr, Bus_WData, ReadData_Memory=0; Bus_BE=0000.
REQ-039 Reset asserted in WAIT or DONE SHALL abandon the access with no ack wait; Bus_Req=0 from that edge.
REQ-040 Mem_Stall and Misaligned SHALL be 0 while Reset is high.

Verification
REQ-041 LB at addr 0x103, Bus_RData=0x80FF_FF00, ack after 2 WAIT cycles -> Mem_Stall high for 3 cycles, then DONE; ReadData_Memory=0xFFFF_FF80.
REQ-042 SH at 0x202, data 0x0000_ABCD -> Bus_Addr=0x200, Bus_BE=1100, Bus_WData=0xABCD_ABCD, Bus_We=1; ReadData_Memory unchanged.
REQ-043 LW at 0x201 -> Misaligned=1, Mem_Stall=0, Bus_Req stays 0.
REQ-044 LHU at 0x0, Bus_Ack never asserted, TIMEOUT_CYCLES=4 -> Bus_Timeout pulses once after 4 WAIT cycles; ReadData_Memory=0; FSM returns to IDLE.
REQ-045 Mem_Read_M=Mem_Write_M=1 -> Bus_We=1 (store performed); Reset pulsed mid-WAIT -> next edge Bus_Req=0, state IDLE, all outputs at reset values.
